// File: rtl/count_seek_pkg.sv
// Shared types and the seek-direction helper for count_seek.
// COUNT_SEEK_WRAP_EN selects a shortest-path direction through counter wrap-around.
package count_pkg;

    localparam int CNT_W = 15;
    localparam logic [CNT_W-1:0] HALF_RANGE = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEEK,
        STEP,
        SETTLE,
        DONE
    } seek_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } seek_dir_t;

    // Which way to strobe the counter to bring q closer to tgt.
    function automatic seek_dir_t seek_dir(input logic [CNT_W-1:0] q,
                                           input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] d;
        seek_dir_t        dir;
        d = tgt - q;
        if (d == '0) begin
            dir = DIR_NONE;
        end else begin
`ifdef COUNT_SEEK_WRAP_EN
            // Forward distance up to half the range (tie included) goes up.
            dir = (d <= HALF_RANGE) ? DIR_UP : DIR_DOWN;
`else
            dir = (tgt > q) ? DIR_UP : DIR_DOWN;
`endif
        end
        return dir;
    endfunction

endpackage

// File: rtl/count_seek_tick_gen.sv
// Step prescaler: counts while enabled, clears synchronously, flags TICK_DIV-1.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
        end
    end

    assign tc = (cnt_reg == LAST);

endmodule

// File: rtl/count_seek.sv
// Step sequencer driving Up/Dw/LD of a loadable up/down counter toward a target.
// Define COUNT_SEEK_WRAP_EN for shortest-path seeking across the counter wrap point.
module count_seek
    import count_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int W        = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic         ld_req,
    input  logic [W-1:0] ld_val,
    input  logic         abort,
    input  logic [W-1:0] Q,
    output logic         Up,
    output logic         Dw,
    output logic         LD,
    output logic [W-1:0] Din,
    output logic         busy,
    output logic         done
);

    seek_state_t  state_reg;
    logic [W-1:0] tgq_reg;
    logic [W-1:0] ldv_reg;
    logic         tick_tc;
    logic         q_hit;
    seek_dir_t    dir;

    assign q_hit = (Q == tgq_reg);
    assign dir   = seek_dir(Q, tgq_reg);

    // Prescaler runs only while waiting in SEEK, so each step period restarts at 0.
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (state_reg != SEEK),
        .en   (state_reg == SEEK),
        .tc   (tick_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tgq_reg   <= '0;
            ldv_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (ld_req) begin
                        ldv_reg   <= ld_val;
                        state_reg <= LOAD;
                    end else if (start) begin
                        tgq_reg   <= target;
                        state_reg <= SEEK;
                    end
                end
                LOAD: state_reg <= IDLE;
                SEEK, STEP, SETTLE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else begin
                        if (start) begin
                            tgq_reg <= target;
                        end
                        if (state_reg == SEEK) begin
                            if (q_hit) begin
                                state_reg <= DONE;
                            end else if (tick_tc) begin
                                state_reg <= STEP;
                            end
                        end else if (state_reg == STEP) begin
                            state_reg <= SETTLE;
                        end else begin
                            state_reg <= SEEK;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Abort in STEP kills the strobe of that same cycle.
    assign Up   = (state_reg == STEP) && !abort && (dir == DIR_UP);
    assign Dw   = (state_reg == STEP) && !abort && (dir == DIR_DOWN);
    assign LD   = (state_reg == LOAD);
    assign Din  = LD ? ldv_reg : '0;
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_count_seek.sv
// Self-checking bench for count_seek: closes the loop through a behavioural counter
// and checks strobe timing/counts against distances computed from the seek rules.
`timescale 1ns/1ps
module tb_count_seek;

    localparam int TD  = 4;
    localparam int PER = TD + 2;
    localparam int WW  = 15;
    localparam int MOD = 1 << WW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ld_req = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] target = '0;
    logic [WW-1:0] ld_val = '0;
    logic [WW-1:0] q_cnt = '0;
    logic          up, dw, ld, busy, done;
    logic [WW-1:0] din;

    int n_checks = 0;
    int n_fail   = 0;
    int up_cnt   = 0;
    int dw_cnt   = 0;
    int ld_cnt   = 0;
    int done_cnt = 0;

    count_seek #(.TICK_DIV(TD), .W(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .target(target),
        .ld_req(ld_req),
        .ld_val(ld_val),
        .abort (abort),
        .Q     (q_cnt),
        .Up    (up),
        .Dw    (dw),
        .LD    (ld),
        .Din   (din),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // The controlled counter: load has priority, 15-bit natural wrap.
    always @(posedge clk) begin
        if (ld)      q_cnt <= din;
        else if (up) q_cnt <= q_cnt + 15'd1;
        else if (dw) q_cnt <= q_cnt - 15'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe_exclusive", 32'($onehot0({up, dw, ld})), 32'd1);
            if (!ld) chk("din_zero_when_idle", 32'(din), 32'd0);
            up_cnt   += int'(up);
            dw_cnt   += int'(dw);
            ld_cnt   += int'(ld);
            done_cnt += int'(done);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected step count and direction from the seek rules.
    task automatic model(input logic [WW-1:0] q, input logic [WW-1:0] t,
                         output int n, output bit go_up);
        int d;
        d = (int'(t) - int'(q) + MOD) % MOD;
`ifdef COUNT_SEEK_WRAP_EN
        go_up = (d <= MOD / 2);
        n     = go_up ? d : MOD - d;
`else
        go_up = (t > q);
        n     = go_up ? int'(t) - int'(q) : int'(q) - int'(t);
`endif
    endtask

    task automatic do_load(input logic [WW-1:0] v, input bit with_start);
        int d0;
        d0 = done_cnt;
        ld_val = v; ld_req = 1'b1; start = with_start; target = v + 15'd7;
        cyc();
        ld_req = 1'b0; start = 1'b0; ld_val = 15'($urandom);
        chk("load_ld_c1", 32'(ld), 32'd1);
        chk("load_din_c1", 32'(din), 32'(v));
        chk("load_busy_c1", 32'(busy), 32'd1);
        cyc();
        chk("load_ld_c2", 32'(ld), 32'd0);
        chk("load_q_c2", 32'(q_cnt), 32'(v));
        chk("load_busy_c2", 32'(busy), 32'd0);
        if (with_start) begin
            cyc();
            chk("load_start_dropped", 32'(busy), 32'd0);
            chk("load_no_done", 32'(done_cnt - d0), 32'd0);
        end
        $display("load  val=%05d start_too=%0d q=%05d", v, with_start, q_cnt);
    endtask

    task automatic do_seek(input logic [WW-1:0] tgt);
        int exp_n, seen, done_at, cycle, lim, l0, d0;
        bit exp_up, partial;
        logic [WW-1:0] q0;
        q0 = q_cnt;
        l0 = ld_cnt;
        d0 = done_cnt;
        model(q0, tgt, exp_n, exp_up);
        partial = (exp_n > 40);
        lim = partial ? 3 * PER + 2 : exp_n * PER + 10;
        target = tgt; start = 1'b1;
        cyc();
        start = 1'b0; target = 15'($urandom);
        seen = 0; done_at = -1; cycle = 1;
        while (1) begin
            if (done_at < 0 && !done) chk("seek_busy", 32'(busy), 32'd1);
            if (up || dw) begin
                chk("step_cycle", 32'(cycle), 32'(TD + 1 + PER * seen));
                chk("step_dir_up", 32'(up), 32'(exp_up));
                seen++;
            end
            if (done) begin
                done_at = cycle;
                break;
            end
            if (partial && seen == 3) break;
            if (cycle >= lim) break;
            cyc();
            cycle++;
        end
        if (partial) begin
            chk("partial_steps", 32'(seen), 32'd3);
            cyc();
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk("partial_abort_busy", 32'(busy), 32'd0);
            chk("partial_no_done", 32'(done_cnt - d0), 32'd0);
        end else begin
            chk("seek_done_cycle", 32'(done_at), 32'(exp_n * PER + 2));
            chk("seek_steps", 32'(seen), 32'(exp_n));
            cyc();
            chk("seek_busy_after", 32'(busy), 32'd0);
            chk("seek_done_single", 32'(done), 32'd0);
            chk("seek_final_q", 32'(q_cnt), 32'(tgt));
        end
        chk("seek_no_ld", 32'(ld_cnt - l0), 32'd0);
        $display("seek  from=%05d to=%05d steps=%0d up=%0d partial=%0d done_at=%0d q=%05d",
                 q0, tgt, exp_n, exp_up, partial, done_at, q_cnt);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int u0, dn0, dc0, l0, done_at;
        logic [WW-1:0] v, t;

        repeat (3) cyc();
        chk("rst_up", 32'(up), 32'd0);
        chk("rst_dw", 32'(dw), 32'd0);
        chk("rst_ld", 32'(ld), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        cyc();

        // Load, then load+start together (load wins).
        do_load(15'h1234, 1'b0);
        do_load(15'd5, 1'b1);

        // Short up seek, already-there seek.
        do_seek(15'd9);
        do_load(15'd100, 1'b0);
        do_seek(15'd100);

        // Abort together with start after two up steps.
        do_load(15'd10, 1'b0);
        target = 15'd20; start = 1'b1; cyc(); start = 1'b0;
        repeat (12) cyc();                      // now in cycle 13
        chk("abort_two_steps", 32'(q_cnt), 32'd12);
        abort = 1'b1; start = 1'b1; target = 15'd0;
        dc0 = done_cnt;
        cyc();
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        u0 = up_cnt; dn0 = dw_cnt;
        repeat (20) cyc();
        chk("abort_no_up", 32'(up_cnt - u0), 32'd0);
        chk("abort_no_dw", 32'(dw_cnt - dn0), 32'd0);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("abort_q", 32'(q_cnt), 32'd12);
        $display("abort after two steps q=%05d", q_cnt);

        // Abort landing on the STEP cycle suppresses that strobe.
        do_load(15'd30, 1'b0);
        target = 15'd40; start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();                       // cycle 5 = first STEP
        chk("step_abort_pre_up", 32'(up), 32'd1);
        abort = 1'b1; #1;
        chk("step_abort_up", 32'(up), 32'd0);
        cyc();
        abort = 1'b0;
        chk("step_abort_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("step_abort_q", 32'(q_cnt), 32'd30);
        $display("abort in step q=%05d", q_cnt);

        // Retarget down mid-seek; ld_req while busy is ignored.
        do_load(15'd50, 1'b0);
        u0 = up_cnt; dn0 = dw_cnt; dc0 = done_cnt; l0 = ld_cnt;
        target = 15'd60; start = 1'b1; cyc(); start = 1'b0;
        repeat (7) cyc();                       // cycle 8
        ld_req = 1'b1; ld_val = 15'd0; cyc(); ld_req = 1'b0;
        repeat (10) cyc();                      // cycle 19
        target = 15'd52; start = 1'b1; cyc(); start = 1'b0;
        done_at = -1;
        for (int c = 20; c < 80; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            cyc();
        end
        chk("retarget_done_cycle", 32'(done_at), 32'd26);
        chk("retarget_ups", 32'(up_cnt - u0), 32'd3);
        chk("retarget_dws", 32'(dw_cnt - dn0), 32'd1);
        chk("retarget_q", 32'(q_cnt), 32'd52);
        chk("busy_ld_ignored", 32'(ld_cnt - l0), 32'd0);
        cyc();
        chk("retarget_done_count", 32'(done_cnt - dc0), 32'd1);
        $display("retarget 60->52 q=%05d done_at=%0d", q_cnt, done_at);

        // Reset mid-seek.
        do_load(15'd100, 1'b0);
        dc0 = done_cnt;
        target = 15'd200; start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();                       // cycle 4
        reset = 1'b1;
        cyc();
        chk("midrst_up", 32'(up), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (10) cyc();
        chk("midrst_q", 32'(q_cnt), 32'd100);
        chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        $display("reset mid-seek q=%05d", q_cnt);

        // Wrap boundaries: shortest path vs linear depending on build.
        do_load(15'd2, 1'b0);
        do_seek(15'd32766);
        do_load(15'd0, 1'b0);
        do_seek(15'd16384);
        do_load(15'd32767, 1'b0);
        do_seek(15'd0);

        // Random short hops (may straddle the wrap point).
        for (int i = 0; i < 15; i++) begin
            v = 15'($urandom);
            t = v + 15'(int'($urandom_range(0, 24)) - 12);
            do_load(v, 1'b0);
            do_seek(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
